regfile_writeback_queue: RTL and testbench

- Write-side initiator for the 16x16 register file.
- Buffers completed results from the execute/memory writeback path in a small in-order queue.
- Drains at most one write per cycle onto the register file's single write port (DstReg/WriteReg/DstData).
- Provides two read-side forwarding lookups so queued, not-yet-committed values reach SrcReg1/SrcReg2 consumers.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wb_fwd_lookup.sv | 34 +++
 rtl/regfile_writeback_queue.sv | 118 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the 16x16 register file write path.
package regfile_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 16;

  typedef logic [REG_W-1:0]  reg_id_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
  } wb_entry_t;

  // R0 is hardwired to zero, so writes to it are swallowed when dropping is enabled.
  function automatic logic drop_write(input bit drop_r0, input reg_id_t rd);
    return drop_r0 && (rd == '0);
  endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search over the live entries of the writeback queue.
module wb_fwd_lookup
  import regfile_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  wb_entry_t        entries [DEPTH],
  input  logic [PTR_W-1:0] head,
  input  logic [CNT_W-1:0] count,
  input  reg_id_t          src,
  output logic             hit,
  output data_t            data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].rd == src) && !drop_write(DROP_R0, src)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with two
// forwarding lookups so queued values are visible to readers before commit.
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [3:0]       wb_reg,
  input  logic [15:0]      wb_data,
  input  logic             drain_en,
  output logic [3:0]       DstReg,
  output logic [15:0]      DstData,
  output logic             WriteReg,
  input  logic [3:0]       SrcReg1,
  input  logic [3:0]       SrcReg2,
  output logic             fwd_hit1,
  output logic [15:0]      fwd_data1,
  output logic             fwd_hit2,
  output logic [15:0]      fwd_data2,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic  full, empty, push, store, pop;
  logic  hit1_raw, hit2_raw;
  data_t data1_raw, data2_raw;

  // Ready looks only at registered occupancy; no path from drain_en.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wb_ready = rst && !full;
  assign pop      = rst && drain_en && !empty;
  assign push     = wb_valid && wb_ready;
  assign store    = push && !drop_write(DROP_R0, wb_reg);

  assign WriteReg = pop;
  assign DstReg   = empty ? '0 : mem_q[head_q].rd;
  assign DstData  = empty ? '0 : mem_q[head_q].data;
  assign count    = count_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (store) begin
      mem_d[tail_q] = '{rd: wb_reg, data: wb_data};
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  wb_fwd_lookup #(
    .DEPTH   (DEPTH),
    .DROP_R0 (DROP_R0)
  ) u_fwd1 (
    .entries (mem_q),
    .head    (head_q),
    .count   (count_q),
    .src     (SrcReg1),
    .hit     (hit1_raw),
    .data    (data1_raw)
  );

  wb_fwd_lookup #(
    .DEPTH   (DEPTH),
    .DROP_R0 (DROP_R0)
  ) u_fwd2 (
    .entries (mem_q),
    .head    (head_q),
    .count   (count_q),
    .src     (SrcReg2),
    .hit     (hit2_raw),
    .data    (data2_raw)
  );

  // Forwarding is suppressed while held in reset; the entries are about to vanish.
  assign fwd_hit1  = rst && hit1_raw;
  assign fwd_data1 = rst ? data1_raw : '0;
  assign fwd_hit2  = rst && hit2_raw;
  assign fwd_data2 = rst ? data2_raw : '0;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomized plus directed bench for the writeback queue against a queue-based model.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             wb_valid;
  logic             wb_ready;
  logic [3:0]       wb_reg;
  logic [15:0]      wb_data;
  logic             drain_en;
  logic [3:0]       DstReg;
  logic [15:0]      DstData;
  logic             WriteReg;
  logic [3:0]       SrcReg1;
  logic [3:0]       SrcReg2;
  logic             fwd_hit1;
  logic [15:0]      fwd_data1;
  logic             fwd_hit2;
  logic [15:0]      fwd_data2;
  logic [CNT_W-1:0] count;

  regfile_writeback_queue #(
    .DEPTH   (DEPTH),
    .DROP_R0 (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .drain_en  (drain_en),
    .DstReg    (DstReg),
    .DstData   (DstData),
    .WriteReg  (WriteReg),
    .SrcReg1   (SrcReg1),
    .SrcReg2   (SrcReg2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] exp_rf [16];
  logic [15:0] dut_rf [16];
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance model at the rising edge.
  task automatic cycle(input logic r, input logic v, input logic [3:0] a_rd, input logic [15:0] a_d,
                       input logic dr, input logic [3:0] s1, input logic [3:0] s2);
    logic        e_rdy, e_we, e_h1, e_h2;
    logic [3:0]  e_dst;
    logic [15:0] e_dd, e_d1, e_d2;
    logic        s_we;
    logic [3:0]  s_reg;
    logic [15:0] s_dat;
    rst = r; wb_valid = v; wb_reg = a_rd; wb_data = a_d; drain_en = dr; SrcReg1 = s1; SrcReg2 = s2;
    e_rdy = r && (mq.size() < DEPTH);
    e_we  = r && dr && (mq.size() != 0);
    e_dst = (mq.size() != 0) ? mq[0].rd   : 4'd0;
    e_dd  = (mq.size() != 0) ? mq[0].data : 16'd0;
    e_h1 = 1'b0; e_d1 = 16'd0; e_h2 = 1'b0; e_d2 = 16'd0;
    foreach (mq[i]) begin
      if (r && s1 != 0 && mq[i].rd == s1) begin e_h1 = 1'b1; e_d1 = mq[i].data; end
      if (r && s2 != 0 && mq[i].rd == s2) begin e_h2 = 1'b1; e_d2 = mq[i].data; end
    end
    @(negedge clk);
    chk("count",    count,     mq.size());
    chk("wb_ready", wb_ready,  e_rdy);
    chk("WriteReg", WriteReg,  e_we);
    chk("DstReg",   DstReg,    e_dst);
    chk("DstData",  DstData,   e_dd);
    chk("fwd_hit1", fwd_hit1,  e_h1);
    chk("fwd_dat1", fwd_data1, e_d1);
    chk("fwd_hit2", fwd_hit2,  e_h2);
    chk("fwd_dat2", fwd_data2, e_d2);
    s_we = WriteReg; s_reg = DstReg; s_dat = DstData;
    @(posedge clk);
    if (s_we) dut_rf[s_reg] = s_dat;
    if (!r) begin
      mq.delete();
    end else begin
      if (e_we) begin
        exp_rf[mq[0].rd] = mq[0].data;
        void'(mq.pop_front());
      end
      if (e_rdy && v && a_rd != 0) mq.push_back('{rd: a_rd, data: a_d});
    end
    #1;
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'd0, 16'd0, dr, 4'd0, 4'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) begin exp_rf[i] = 16'd0; dut_rf[i] = 16'd0; end
    rst = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0; drain_en = 1'b0;
    SrcReg1 = '0; SrcReg2 = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b0, 1'b1, 4'd5, 16'h1234, 1'b1, 4'd5, 4'd0);
    idle(1, 1'b1);

    // single write
    cycle(1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b1, 4'd3, 4'd0);
    chk("single_cnt", count, 1);
    idle(2, 1'b1);
    chk("rf_r3", dut_rf[3], 16'hBEEF);

    // fill, hold fifth push, then drain in order
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 4'(i), 16'(i * 16'h0011), 1'b0, 4'd2, 4'd4);
    chk("fill_cnt", count, 4);
    chk("fill_rdy", wb_ready, 0);
    cycle(1'b1, 1'b1, 4'd5, 16'h0055, 1'b0, 4'd5, 4'd1);
    cycle(1'b1, 1'b1, 4'd5, 16'h0055, 1'b1, 4'd5, 4'd1);
    cycle(1'b1, 1'b1, 4'd5, 16'h0055, 1'b1, 4'd5, 4'd1);
    idle(4, 1'b1);
    chk("rf_r4", dut_rf[4], 16'h0044);
    chk("rf_r5", dut_rf[5], 16'h0055);

    // youngest forwarding
    cycle(1'b1, 1'b1, 4'd7, 16'h1111, 1'b0, 4'd7, 4'd8);
    cycle(1'b1, 1'b1, 4'd7, 16'h2222, 1'b0, 4'd7, 4'd8);
    chk("fwd_young", fwd_data1, 16'h2222);
    cycle(1'b1, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 4'd8);
    idle(2, 1'b1);
    chk("rf_r7", dut_rf[7], 16'h2222);

    // R0 is accepted and dropped
    cycle(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0);
    chk("r0_cnt", count, 0);
    idle(2, 1'b1);

    // steady push+pop across pointer wrap
    cycle(1'b1, 1'b1, 4'd9, 16'hA0A0, 1'b0, 4'd9, 4'd0);
    cycle(1'b1, 1'b1, 4'd6, 16'hA1A1, 1'b0, 4'd6, 4'd9);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'b1, 4'(1 + i % 15), 16'hB000 + 16'(i), 1'b1, 4'(1 + i % 15), 4'd9);
    chk("wrap_cnt", count, 2);
    idle(3, 1'b1);

    // reset with entries queued cancels them
    cycle(1'b1, 1'b1, 4'd10, 16'hC00A, 1'b0, 4'd10, 4'd0);
    cycle(1'b1, 1'b1, 4'd11, 16'hC00B, 1'b0, 4'd11, 4'd0);
    cycle(1'b1, 1'b1, 4'd12, 16'hC00C, 1'b0, 4'd12, 4'd0);
    cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd10, 4'd12);
    cycle(1'b1, 1'b0, 4'd0, 16'd0, 1'b1, 4'd10, 4'd12);
    chk("rst_r12", dut_rf[12], 16'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
            16'($urandom), ($urandom_range(0, 9) < 5), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    idle(DEPTH + 2, 1'b1);

    for (int r = 0; r < 16; r++) chk($sformatf("rf%0d", r), dut_rf[r], exp_rf[r]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
